// File: rtl/rob_multi.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rob_multi : in-order-retire reorder buffer with NUM_WB writeback ports.  |
// | Optional squash port enabled by defining ROB_FLUSH_EN.                   |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module rob_multi #(
  parameter int DEPTH  = 32,
  parameter int NUM_WB = 3,
  parameter int XLEN   = 32,
  parameter int PREG_W = 5,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    allocate_req_i,
  input  logic [PREG_W-1:0]       prd_addr_i,
  input  logic [XLEN-1:0]         pc_i,
  input  logic [XLEN-1:0]         inst_i,
  output logic [IDX_W-1:0]        rob_idx_o,
  output logic                    alloc_ack_o,
  output logic                    empty_o,
  output logic                    full_o,
  output logic [IDX_W:0]          count_o,
  input  logic [NUM_WB-1:0]       wb_valid_i,
  input  logic [NUM_WB*IDX_W-1:0] wb_idx_i,
  input  logic [NUM_WB*XLEN-1:0]  wb_value_i,
  output logic                    commit_valid_o,
  output logic [XLEN-1:0]         inst_committed_o,
  output logic [XLEN-1:0]         pc_committed_o,
  output logic [PREG_W-1:0]       prd_addr_committed_o,
  output logic [XLEN-1:0]         prd_value_committed_o
`ifdef ROB_FLUSH_EN
  ,
  input  logic                    flush_i,
  input  logic [IDX_W-1:0]        flush_idx_i
`endif
);

  logic [IDX_W:0]      r_head, r_tail;
  logic [DEPTH-1:0]    r_valid, r_done;
  logic [XLEN-1:0]     r_pc    [DEPTH];
  logic [XLEN-1:0]     r_inst  [DEPTH];
  logic [XLEN-1:0]     r_value [DEPTH];
  logic [PREG_W-1:0]   r_prd   [DEPTH];

  logic                r_cm_valid;
  logic [XLEN-1:0]     r_cm_pc, r_cm_inst, r_cm_value;
  logic [PREG_W-1:0]   r_cm_prd;

  logic [IDX_W-1:0]    w_head_idx, w_tail_idx;
  logic                w_full, w_empty, w_alloc, w_commit, w_flush;
  logic [IDX_W:0]      w_tail_nxt;
  logic [DEPTH-1:0]    w_wb_hit, w_squash, w_valid_nxt, w_done_nxt;
  logic [XLEN-1:0]     w_wb_val [DEPTH];

  assign w_head_idx = r_head[IDX_W-1:0];
  assign w_tail_idx = r_tail[IDX_W-1:0];
  assign w_empty    = (r_head == r_tail);
  assign w_full     = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);
  assign w_alloc    = allocate_req_i & ~w_full & ~w_flush;
  assign w_commit   = r_valid[w_head_idx] & r_done[w_head_idx];

`ifdef ROB_FLUSH_EN
  logic [IDX_W-1:0] w_flush_ofs;

  assign w_flush     = flush_i & r_valid[flush_idx_i];
  assign w_flush_ofs = flush_idx_i - w_head_idx;

  // Age is the distance from the head; anything older-than-or-equal survives.
  always_comb begin
    w_squash = '0;
    for (int e = 0; e < DEPTH; e++) begin
      w_squash[e] = w_flush && ((IDX_W'(e) - w_head_idx) > w_flush_ofs);
    end
  end

  assign w_tail_nxt = w_flush ? (r_head + {1'b0, w_flush_ofs} + (IDX_W+1)'(1))
                              : (r_tail + {{IDX_W{1'b0}}, w_alloc});
`else
  assign w_flush    = 1'b0;
  assign w_squash   = '0;
  assign w_tail_nxt = r_tail + {{IDX_W{1'b0}}, w_alloc};
`endif

  // Ascending port order lets the highest-numbered port win a collision.
  always_comb begin
    for (int e = 0; e < DEPTH; e++) begin
      w_wb_hit[e] = 1'b0;
      w_wb_val[e] = '0;
      for (int k = 0; k < NUM_WB; k++) begin
        if (wb_valid_i[k] && (wb_idx_i[k*IDX_W +: IDX_W] == IDX_W'(e))) begin
          w_wb_hit[e] = 1'b1;
          w_wb_val[e] = wb_value_i[k*XLEN +: XLEN];
        end
      end
    end
  end

  always_comb begin
    w_valid_nxt = r_valid;
    w_done_nxt  = r_done;
    for (int e = 0; e < DEPTH; e++) begin
      if (w_wb_hit[e] && r_valid[e]) w_done_nxt[e] = 1'b1;
    end
    if (w_commit) w_valid_nxt[w_head_idx] = 1'b0;
    w_valid_nxt = w_valid_nxt & ~w_squash;
    if (w_alloc) begin
      w_valid_nxt[w_tail_idx] = 1'b1;
      w_done_nxt[w_tail_idx]  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_valid    <= '0;
      r_done     <= '0;
      r_cm_valid <= 1'b0;
      r_cm_pc    <= '0;
      r_cm_inst  <= '0;
      r_cm_value <= '0;
      r_cm_prd   <= '0;
    end else begin
      r_valid    <= w_valid_nxt;
      r_done     <= w_done_nxt;
      r_tail     <= w_tail_nxt;
      r_cm_valid <= w_commit;
      if (w_commit) begin
        r_head     <= r_head + (IDX_W+1)'(1);
        r_cm_pc    <= r_pc[w_head_idx];
        r_cm_inst  <= r_inst[w_head_idx];
        r_cm_value <= r_value[w_head_idx];
        r_cm_prd   <= r_prd[w_head_idx];
      end
    end
  end

  // Payload storage is qualified by valid bits, so it needs no reset.
  always_ff @(posedge clk_i) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (w_wb_hit[e] && r_valid[e]) r_value[e] <= w_wb_val[e];
    end
    if (w_alloc) begin
      r_pc[w_tail_idx]   <= pc_i;
      r_inst[w_tail_idx] <= inst_i;
      r_prd[w_tail_idx]  <= prd_addr_i;
    end
  end

  assign rob_idx_o             = w_tail_idx;
  assign alloc_ack_o           = w_alloc;
  assign empty_o               = w_empty;
  assign full_o                = w_full;
  assign count_o               = r_tail - r_head;
  assign commit_valid_o        = r_cm_valid;
  assign pc_committed_o        = r_cm_pc;
  assign inst_committed_o      = r_cm_inst;
  assign prd_addr_committed_o  = r_cm_prd;
  assign prd_value_committed_o = r_cm_value;

endmodule
`default_nettype wire
